exhaust_ctrl_multi: RTL and testbench

Parametrised range-hood exhaust controller: N fan levels, with the top level acting as a timed "boost" (hurricane) mode.
- Boost may be used once per power-on session.
- Pressing menu during boost starts a forced return-to-standby countdown.
- Timers advance on an external 1 Hz strobe rather than on every clock.
- Sits between the key-debounce/edge block and the display/fan-drive blocks.

---
 rtl/exhaust_pkg.sv | 13 +
 rtl/exhaust_ctrl_multi_if.sv | 28 ++
 rtl/exhaust_countdown.sv | 23 ++
 rtl/exhaust_ctrl_multi.sv | 131 +++++++++++++
 tb/tb_exhaust_ctrl_multi.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/exhaust_pkg.sv
// Shared types and default durations for the range-hood exhaust controller.
package exhaust_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_RUN,
    ST_BOOST,
    ST_RETURN
  } state_e;

  localparam int DEF_BOOST_SECS  = 60;
  localparam int DEF_RETURN_SECS = 60;
endpackage

// File: rtl/exhaust_ctrl_multi_if.sv
// Key inputs and status outputs between the debounce front end and the display/fan drive.
interface exhaust_ctrl_multi_if #(
  parameter int NUM_LEVELS = 3,
  parameter int CNT_W      = 8
);
  localparam int LVL_W = $clog2(NUM_LEVELS + 1);

  logic                  tick;
  logic                  power_on;
  logic                  menu_key;
  logic [NUM_LEVELS-1:0] level_key;
  logic [LVL_W-1:0]      level;
  logic [CNT_W-1:0]      countdown;
  logic                  countdown_active;
  logic                  busy;
  logic                  in_select;
  logic                  boost_used;

  modport master (
    output tick, power_on, menu_key, level_key,
    input  level, countdown, countdown_active, busy, in_select, boost_used
  );

  modport slave (
    input  tick, power_on, menu_key, level_key,
    output level, countdown, countdown_active, busy, in_select, boost_used
  );
endinterface

// File: rtl/exhaust_countdown.sv
// Tick-driven down counter shared by the boost and return timers; saturates at 0.
module exhaust_countdown #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             done
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (clr)                  count <= '0;
    else if (load)                 count <= value;
    else if (tick && count != '0)  count <= count - 1'b1;
  end

  // done flags the tick that consumes the last second
  assign done = tick && (count == CNT_W'(1));
endmodule

// File: rtl/exhaust_ctrl_multi.sv
// Exhaust fan level controller: menu/level keys, one-shot timed boost, forced return countdown.
module exhaust_ctrl_multi
  import exhaust_pkg::*;
#(
  parameter int NUM_LEVELS  = 3,
  parameter int BOOST_SECS  = DEF_BOOST_SECS,
  parameter int RETURN_SECS = DEF_RETURN_SECS,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  exhaust_ctrl_multi_if.slave  bus
);
  localparam int LVL_W = $clog2(NUM_LEVELS + 1);

  if (NUM_LEVELS < 2 || BOOST_SECS < 1 || RETURN_SECS < 1 ||
      BOOST_SECS > (2**CNT_W) - 1 || RETURN_SECS > (2**CNT_W) - 1) begin : g_bad_param
    $error("exhaust_ctrl_multi: illegal parameter set");
  end

  state_e           state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             used_q, pwr_q;
  logic             set_used, clr, load, take_key;
  logic [CNT_W-1:0] load_val, count;
  logic             done;
  logic             key_hit, key_boost, key_ok;
  logic [LVL_W-1:0] key_lvl;
  logic [LVL_W-1:0] lvl_out;

  exhaust_countdown #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .value(load_val),
    .tick(bus.tick), .count(count), .done(done)
  );

  // Lowest set bit wins; an exhausted boost key is dropped, not remapped.
  always_comb begin
    key_hit = 1'b0;
    key_lvl = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (bus.level_key[i]) begin
        key_hit = 1'b1;
        key_lvl = LVL_W'(i + 1);
      end
    end
    key_boost = (key_lvl == LVL_W'(NUM_LEVELS));
    key_ok    = key_hit && !(key_boost && used_q);
  end

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    set_used = 1'b0;
    take_key = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (bus.menu_key) state_d = ST_SELECT;
      ST_SELECT: take_key = !bus.menu_key && key_ok;
      ST_RUN: begin
        if (bus.menu_key) state_d = ST_IDLE;
        else              take_key = key_ok;
      end
      ST_BOOST: begin
        if (bus.menu_key) begin
          state_d  = ST_RETURN;
          load     = 1'b1;
          load_val = CNT_W'(RETURN_SECS);
        end else if (done) begin
          state_d = ST_RUN;
          lvl_d   = LVL_W'(NUM_LEVELS - 1);
          clr     = 1'b1;
        end
      end
      ST_RETURN: if (done) begin
        state_d = ST_IDLE;
        clr     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (take_key) begin
      if (key_boost) begin
        state_d  = ST_BOOST;
        load     = 1'b1;
        load_val = CNT_W'(BOOST_SECS);
        set_used = 1'b1;
      end else begin
        state_d = ST_RUN;
        lvl_d   = key_lvl;
      end
    end
    // Power loss overrides everything except the session's boost flag.
    if (!bus.power_on) begin
      state_d  = ST_IDLE;
      clr      = 1'b1;
      load     = 1'b0;
      set_used = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      used_q  <= 1'b0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      pwr_q   <= bus.power_on;
      if (set_used)                  used_q <= 1'b1;
      else if (bus.power_on && !pwr_q) used_q <= 1'b0;
    end
  end

  always_comb begin
    unique case (state_q)
      ST_RUN:              lvl_out = lvl_q;
      ST_BOOST, ST_RETURN: lvl_out = LVL_W'(NUM_LEVELS);
      default:             lvl_out = '0;
    endcase
  end

  assign bus.level            = lvl_out;
  assign bus.busy             = (lvl_out != '0);
  assign bus.countdown_active = (state_q == ST_BOOST) || (state_q == ST_RETURN);
  assign bus.countdown        = bus.countdown_active ? count : '0;
  assign bus.in_select        = (state_q == ST_SELECT);
  assign bus.boost_used       = used_q;
endmodule

// File: tb/tb_exhaust_ctrl_multi.sv
// Directed plan plus randomized traffic, checked every cycle against a behavioural hood model.
module tb_exhaust_ctrl_multi;
  localparam int NL  = 3;
  localparam int BS  = 5;
  localparam int RS  = 3;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  exhaust_ctrl_multi_if #(.NUM_LEVELS(NL), .CNT_W(CW)) bus ();

  exhaust_ctrl_multi #(
    .NUM_LEVELS(NL), .BOOST_SECS(BS), .RETURN_SECS(RS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: fan level, remaining seconds, menu open, returning, session boost flag.
  int m_lvl, m_tmr;
  bit m_sel, m_ret, m_used, m_pq;

  always @(posedge clk or posedge rst) begin
    int lvl, tmr, k;
    bit sel, ret, used;
    if (rst) begin
      m_lvl <= 0; m_tmr <= 0; m_sel <= 0; m_ret <= 0; m_used <= 0; m_pq <= 0;
    end else begin
      lvl = m_lvl; tmr = m_tmr; sel = m_sel; ret = m_ret; used = m_used;
      k = 0;
      for (int i = NL - 1; i >= 0; i--) if (bus.level_key[i]) k = i + 1;
      if (bus.power_on && !m_pq) used = 0;
      if (!bus.power_on) begin
        lvl = 0; tmr = 0; sel = 0; ret = 0;
      end else if (ret) begin
        if (bus.tick) begin
          tmr = tmr - 1;
          if (tmr == 0) begin lvl = 0; ret = 0; end
        end
      end else if (lvl == NL) begin
        if (bus.menu_key) begin ret = 1; tmr = RS; end
        else if (bus.tick) begin
          tmr = tmr - 1;
          if (tmr == 0) lvl = NL - 1;
        end
      end else if (sel || lvl != 0) begin
        if (bus.menu_key) begin
          if (!sel) lvl = 0;
        end else if (k != 0 && !(k == NL && used)) begin
          sel = 0;
          lvl = k;
          if (k == NL) begin tmr = BS; used = 1; end
        end
      end else if (bus.menu_key) begin
        sel = 1;
      end
      m_lvl <= lvl; m_tmr <= tmr; m_sel <= sel; m_ret <= ret; m_used <= used;
      m_pq  <= bus.power_on;
    end
  end

  always @(negedge clk) begin
    logic [13:0] exp_v, act_v;
    exp_v = {2'(m_lvl), 8'(m_tmr), m_lvl == NL, m_lvl != 0, m_sel, m_used};
    act_v = {bus.level, bus.countdown, bus.countdown_active, bus.busy,
             bus.in_select, bus.boost_used};
    n_chk++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL model t=%0t got=%h want=%h", $time, act_v, exp_v);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", nm, act, exp);
  endtask

  task automatic drive(input bit t, input bit m, input logic [NL-1:0] lk);
    bus.tick = t; bus.menu_key = m; bus.level_key = lk;
    @(posedge clk); #1;
    bus.tick = 0; bus.menu_key = 0; bus.level_key = '0;
  endtask

  task automatic chk_all(input string nm, input int lv, input int cd, input int act,
                         input int sel, input int used);
    chk({nm, ".level"}, int'(bus.level), lv);
    chk({nm, ".countdown"}, int'(bus.countdown), cd);
    chk({nm, ".active"}, int'(bus.countdown_active), act);
    chk({nm, ".busy"}, int'(bus.busy), int'(lv != 0));
    chk({nm, ".in_select"}, int'(bus.in_select), sel);
    chk({nm, ".boost_used"}, int'(bus.boost_used), used);
  endtask

  initial begin
    bus.tick = 0; bus.menu_key = 0; bus.level_key = '0; bus.power_on = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 0;
    drive(0, 0, '0);
    // 1: menu then level 2
    drive(0, 1, '0);          chk_all("t1.sel", 0, 0, 0, 1, 0);
    drive(0, 0, 3'b010);      chk_all("t1.run", 2, 0, 0, 0, 0);
    // 2: boost runs out back to level 2
    drive(0, 0, 3'b100);      chk_all("t2.boost", 3, 5, 1, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, '0);
      chk("t2.cd", int'(bus.countdown), 5 - i);
    end
    drive(1, 0, '0);          chk_all("t2.exit", 2, 0, 0, 0, 1);
    // 3: second boost ignored until power cycle
    drive(0, 0, 3'b100);      chk_all("t3.ignored", 2, 0, 0, 0, 1);
    bus.power_on = 0;
    drive(0, 0, '0);          chk_all("t3.off", 0, 0, 0, 0, 1);
    bus.power_on = 1;
    drive(0, 0, '0);          chk("t3.cleared", int'(bus.boost_used), 0);
    drive(0, 1, '0);
    drive(0, 0, 3'b100);      chk_all("t3.boost", 3, 5, 1, 0, 1);
    // 4: menu in boost forces return
    drive(1, 0, '0);          chk("t4.cd4", int'(bus.countdown), 4);
    drive(0, 1, '0);          chk_all("t4.ret", 3, 3, 1, 0, 1);
    drive(0, 0, 3'b111);      chk_all("t4.keyign", 3, 3, 1, 0, 1);
    drive(1, 0, '0);          chk("t4.cd2", int'(bus.countdown), 2);
    drive(1, 0, '0);          chk("t4.cd1", int'(bus.countdown), 1);
    drive(1, 0, '0);          chk_all("t4.idle", 0, 0, 0, 0, 1);
    // 5: menu wins over level keys in select
    drive(0, 1, '0);
    drive(0, 1, 3'b110);      chk_all("t5.stay", 0, 0, 0, 1, 1);
    drive(0, 0, 3'b110);      chk_all("t5.run2", 2, 0, 0, 0, 1);
    // 6: reset mid-boost
    bus.power_on = 0; drive(0, 0, '0);
    bus.power_on = 1; drive(0, 0, '0);
    drive(0, 1, '0);
    drive(0, 0, 3'b100);
    repeat (3) drive(1, 0, '0);
    chk("t6.cd2", int'(bus.countdown), 2);
    rst = 1;
    #1;                       chk_all("t6.rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;       chk_all("t6.rsthold", 0, 0, 0, 0, 0);
    rst = 0;
    drive(0, 0, '0);
    drive(0, 1, '0);
    drive(0, 0, 3'b100);      chk_all("t6.boost", 3, 5, 1, 0, 1);
    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [NL-1:0] lk;
      if ($urandom_range(0, 99) == 0) bus.power_on = ~bus.power_on;
      if ($urandom_range(0, 19) == 0) bus.power_on = 1;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1;
        drive(0, 0, '0);
        rst = 0;
      end
      lk = ($urandom_range(0, 5) == 0) ? NL'($urandom_range(1, 7)) : '0;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, lk);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
